// File: rtl/mux4_arbiter.sv
// mux4_arbiter: round-robin arbiter and registered datapath that time-shares
// a 4:1 mux between four requesters with bounded per-grant bursts.
// Optional macro MUX4_ARB_FIXED_PRI_EN: when defined, winner selection is
// fixed priority (lowest index first) instead of round-robin.
module mux4_arbiter #(
   parameter int WIDTH    = 4,
   parameter int MAXBURST = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   output logic [3:0]       gnt,
   output logic [1:0]       s,
   output logic [WIDTH-1:0] y,
   output logic             valid,
   output logic             busy
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [4:0] MAXB = 5'(MAXBURST);

   state_t           state, state_nx;
   logic [3:0]       gnt_nx;
   logic [1:0]       s_nx;
   logic [WIDTH-1:0] y_nx;
   logic             valid_nx;
   logic [3:0]       cnt, cnt_nx;
   logic [1:0]       last, last_nx;
   logic [4:0]       cnt_inc;
   logic [WIDTH-1:0] d_sel;
   logic             rel;
   logic [1:0]       win;

   // First set request bit searching upward from the slot after 'from'.
   // Starting from 3 makes the search plain lowest-index-first.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] from);
      logic [1:0] w;
      logic [1:0] idx;
      logic       found;
      w     = 2'd0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = from + 2'(k);
         if (r[idx] && !found) begin
            w     = idx;
            found = 1'b1;
         end
      end
      return w;
   endfunction

   // Operand currently addressed by the select, i.e. what the mux would pass.
   always_comb begin
      d_sel = d0;
      case (s)
         2'd0:    d_sel = d0;
         2'd1:    d_sel = d1;
         2'd2:    d_sel = d2;
         default: d_sel = d3;
      endcase
   end

   // Next-state, grant, burst count and datapath decisions for the coming edge.
   always_comb begin
      state_nx = state;
      gnt_nx   = gnt;
      s_nx     = s;
      y_nx     = y;
      valid_nx = 1'b0;
      cnt_nx   = cnt;
      last_nx  = last;
      rel      = 1'b0;
      win      = 2'd0;
      cnt_inc  = {1'b0, cnt} + 5'd1;
      case (state)
         IDLE: begin
            if (req != 4'd0) begin
`ifdef MUX4_ARB_FIXED_PRI_EN
               win = pick(req, 2'd3);
`else
               win = pick(req, last);
`endif
               state_nx = GRANT;
               gnt_nx   = 4'b0001 << win;
               s_nx     = win;
               cnt_nx   = 4'd0;
            end
         end
         default: begin
            if (req[s]) begin
               y_nx     = d_sel;
               valid_nx = 1'b1;
               cnt_nx   = cnt_inc[3:0];
               rel      = (cnt_inc == MAXB);
            end else begin
               rel = 1'b1;
            end
            if (rel) begin
               last_nx = s;
               cnt_nx  = 4'd0;
               if (req != 4'd0) begin
`ifdef MUX4_ARB_FIXED_PRI_EN
                  win = pick(req, 2'd3);
`else
                  win = pick(req, s);
`endif
                  gnt_nx = 4'b0001 << win;
                  s_nx   = win;
               end else begin
                  state_nx = IDLE;
                  gnt_nx   = 4'd0;
               end
            end
         end
      endcase
   end

   // State and output registers; reset clears everything at once and points
   // the round-robin pointer at 3 so the first search begins with requester 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= 4'd0;
         s     <= 2'd0;
         y     <= '0;
         valid <= 1'b0;
         cnt   <= 4'd0;
         last  <= 2'd3;
      end else begin
         state <= state_nx;
         gnt   <= gnt_nx;
         s     <= s_nx;
         y     <= y_nx;
         valid <= valid_nx;
         cnt   <= cnt_nx;
         last  <= last_nx;
      end
   end

   assign busy = (state == GRANT);

endmodule

// File: tb/tb_mux4_arbiter.sv
// tb_mux4_arbiter: scoreboard bench for mux4_arbiter; a transaction-level
// model predicts each edge's outputs and a monitor compares them.
module tb_mux4_arbiter;

   localparam int W    = 4;
   localparam int MAXB = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req = 4'd0;
   logic [W-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
   logic [3:0]   gnt;
   logic [1:0]   s;
   logic [W-1:0] y;
   logic         valid;
   logic         busy;

   typedef struct {
      logic [3:0]   gnt;
      logic [1:0]   s;
      logic [W-1:0] y;
      logic         valid;
      logic         busy;
   } exp_t;

   exp_t expq[$];

   int checks = 0;
   int errors = 0;

   // Model: who holds the mux (-1 = nobody), transfers used, last holder,
   // select value and last delivered operand.
   int           m_holder;
   int           m_used;
   int           m_last;
   int           m_sel;
   logic [W-1:0] m_y;
   logic         m_valid;

   mux4_arbiter #(.WIDTH(W), .MAXBURST(MAXB)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .gnt(gnt), .s(s), .y(y), .valid(valid), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic int pick_winner(input logic [3:0] r, input int from);
`ifdef MUX4_ARB_FIXED_PRI_EN
      for (int i = 0; i < 4; i++) if (r[i]) return i;
`else
      for (int k = 1; k <= 4; k++) if (r[(from + k) % 4]) return (from + k) % 4;
`endif
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, want);
      end
   endtask

   task automatic push_expect();
      exp_t ex;
      ex.gnt   = (m_holder >= 0) ? 4'(1 << m_holder) : 4'd0;
      ex.s     = 2'(m_sel);
      ex.y     = m_y;
      ex.valid = m_valid;
      ex.busy  = (m_holder >= 0);
      expq.push_back(ex);
   endtask

   task automatic model_reset();
      m_holder = -1;
      m_used   = 0;
      m_last   = 3;
      m_sel    = 0;
      m_y      = '0;
      m_valid  = 1'b0;
   endtask

   task automatic model_step();
      logic [W-1:0] dv [4];
      bit           rel;
      dv      = '{d0, d1, d2, d3};
      m_valid = 1'b0;
      rel     = 1'b0;
      if (m_holder < 0) begin
         if (req != 4'd0) begin
            m_holder = pick_winner(req, m_last);
            m_sel    = m_holder;
            m_used   = 0;
         end
      end else begin
         if (req[m_holder]) begin
            m_y     = dv[m_holder];
            m_valid = 1'b1;
            m_used++;
            rel = (m_used == MAXB);
         end else begin
            rel = 1'b1;
         end
         if (rel) begin
            m_last = m_holder;
            m_used = 0;
            if (req != 4'd0) begin
               m_holder = pick_winner(req, m_last);
               m_sel    = m_holder;
            end else begin
               m_holder = -1;
            end
         end
      end
   endtask

   // Drive one cycle of inputs on the falling edge and predict the next rising edge.
   task automatic applyStimulus(input logic rst, input logic [3:0] r,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c, input logic [W-1:0] e);
      @(negedge clk);
      rst_n = rst;
      req   = r;
      d0 = a; d1 = b; d2 = c; d3 = e;
      if (!rst) model_reset();
      else model_step();
      push_expect();
   endtask

   // Monitor: after every rising edge, pop the prediction and compare.
   initial begin
      exp_t ex;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            ex = expq.pop_front();
            checkOutput("gnt",   32'(gnt),   32'(ex.gnt));
            checkOutput("s",     32'(s),     32'(ex.s));
            checkOutput("y",     32'(y),     32'(ex.y));
            checkOutput("valid", 32'(valid), 32'(ex.valid));
            checkOutput("busy",  32'(busy),  32'(ex.busy));
         end
      end
   end

   initial begin
      logic [3:0] r;
      int         drain;
      model_reset();
      $display("[TB] start");

      // Reset held with every requester asking, then release.
      #2;
      checkOutput("reset_gnt", 32'(gnt), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      repeat (3) applyStimulus(1'b0, 4'b1111, 4'd2, 4'd4, 4'd6, 4'd9);

      // Full contention: rotation 0,1,2,3,0 in bursts of four.
      repeat (22) applyStimulus(1'b1, 4'b1111, 4'd2, 4'd4, 4'd6, 4'd9);

      // Idle return, then a lone requester re-granted without a bubble.
      repeat (2) applyStimulus(1'b1, 4'b0000, 4'd2, 4'd4, 4'd6, 4'd9);
      repeat (8) applyStimulus(1'b1, 4'b0001, 4'd2, 4'd4, 4'd6, 4'd9);
      repeat (2) applyStimulus(1'b1, 4'b0000, 4'd2, 4'd4, 4'd6, 4'd9);

      // Early drop: requester 1 leaves last=1, so 0101 grants 2 first.
      repeat (2) applyStimulus(1'b1, 4'b0010, 4'd3, 4'd5, 4'd6, 4'd9);
      repeat (3) applyStimulus(1'b1, 4'b0101, 4'd3, 4'd5, 4'd6, 4'd9);
      repeat (2) applyStimulus(1'b1, 4'b0001, 4'd3, 4'd5, 4'd6, 4'd9);
      repeat (2) applyStimulus(1'b1, 4'b0000, 4'd3, 4'd5, 4'd6, 4'd9);

      // Randomised traffic with sticky request patterns and occasional resets.
      r = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         applyStimulus(($urandom_range(0, 99) != 0), r,
                       4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)),
                       4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
      end

      // Asynchronous reset in the middle of a burst.
      repeat (6) applyStimulus(1'b1, 4'b1111, 4'd7, 4'd8, 4'd10, 4'd12);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("async_gnt",   32'(gnt),   32'd0);
      checkOutput("async_s",     32'(s),     32'd0);
      checkOutput("async_y",     32'(y),     32'd0);
      checkOutput("async_valid", 32'(valid), 32'd0);
      checkOutput("async_busy",  32'(busy),  32'd0);
      applyStimulus(1'b0, 4'b1111, 4'd7, 4'd8, 4'd10, 4'd12);
      repeat (6) applyStimulus(1'b1, 4'b1111, 4'd7, 4'd8, 4'd10, 4'd12);
      repeat (2) applyStimulus(1'b1, 4'b0000, 4'd7, 4'd8, 4'd10, 4'd12);

      // Let the monitor consume every outstanding prediction, bounded.
      drain = 0;
      while (expq.size() > 0 && drain < 20) begin
         @(posedge clk);
         drain++;
      end
      #2;
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", expq.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
